// File: rtl/oled_pkg.sv
// Shared definitions for the OLED refresh path: scheduler states, transfer
// kinds and snapshot widths used by the scheduler, sequencer and I2C master.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP     = 3'd0,
        ST_INIT_START  = 3'd1,
        ST_INIT_WAIT   = 3'd2,
        ST_IDLE        = 3'd3,
        ST_FRAME_START = 3'd4,
        ST_FRAME_WAIT  = 3'd5
    } sched_state_e;

    localparam logic KIND_INIT  = 1'b0;
    localparam logic KIND_FRAME = 1'b1;

    localparam int SCREEN_W = 8;
    localparam int NEEDS_W  = 33;

    typedef struct packed {
        logic [SCREEN_W-1:0] screen;
        logic [NEEDS_W-1:0]  needs;
    } snapshot_t;

    // Largest of four cycle counts; sizes the shared counter width.
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/oled_sched_timer.sv
// Saturating cycle counter: clear has priority, counts while enabled and
// stops once the run-time limit is reached.
module oled_sched_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         reached_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign reached_o = (cnt_q >= limit_i);

    // Next count: clear, else increment until the limit is hit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !reached_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/oled_refresh_scheduler.sv
// Sequences the SSD1306 path: power-up hold-off, one-time init, then
// rate-limited frame refreshes on input change or idle timeout, with a
// watchdog on every transfer and a snapshot frozen across each frame.
module oled_refresh_scheduler
    import oled_pkg::*;
#(
    parameter int unsigned INIT_DELAY_CYCLES = 5_000_000,
    parameter int unsigned MIN_GAP_CYCLES    = 2_500_000,
    parameter int unsigned MAX_IDLE_CYCLES   = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES    = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SCREEN_W-1:0] screen_param,
    input  logic [NEEDS_W-1:0]  needs_values,
    input  logic                seq_done,
    output logic                start,
    output logic                start_kind,
    output logic [SCREEN_W-1:0] screen_param_q,
    output logic [NEEDS_W-1:0]  needs_values_q,
    output logic                ready,
    output logic                err,
    output logic [15:0]         frame_count
);

    localparam int CW = $clog2(max4(INIT_DELAY_CYCLES, MIN_GAP_CYCLES,
                                    MAX_IDLE_CYCLES, TIMEOUT_CYCLES)) + 1;

    // Hold-off and watchdog are compared against limit-1 so the state occupies
    // exactly N cycles before the exit edge (the counter starts at 0 on entry).
    localparam logic [CW-1:0] HOLD_LIM = CW'(INIT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LIM  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LIM  = CW'(MIN_GAP_CYCLES);
    localparam logic [CW-1:0] IDLE_LIM = CW'(MAX_IDLE_CYCLES);

    sched_state_e        state_q, state_d;
    logic                start_q, start_d;
    logic                kind_q, kind_d;
    logic [SCREEN_W-1:0] sp_d;
    logic [NEEDS_W-1:0]  nv_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [15:0]         fc_q, fc_d;
    logic                gap_sat_q, gap_sat_d;

    logic                hold_clr, hold_en, hold_reached;
    logic [CW-1:0]       hold_lim;
    logic                gap_clr, gap_en, gap_reached;
    logic                idle_clr, idle_en, idle_reached;
    logic                done_v, dirty, gap_ok;

    // seq_done is only honoured in the WAIT states and never in the cycle
    // that start is still high (that pulse cannot belong to this transfer).
    assign done_v = seq_done && !start_q &&
                    ((state_q == ST_INIT_WAIT) || (state_q == ST_FRAME_WAIT));
    assign dirty  = ({screen_param, needs_values} != {screen_param_q, needs_values_q});
    assign gap_ok = gap_reached || gap_sat_q;

    // Shared hold-off / watchdog timer, restarted on every state change.
    assign hold_clr = (state_d != state_q);
    assign hold_en  = (state_q == ST_POWERUP) || (state_q == ST_INIT_WAIT) ||
                      (state_q == ST_FRAME_WAIT);
    assign hold_lim = (state_q == ST_POWERUP) ? HOLD_LIM : TMO_LIM;

    oled_sched_timer #(.W(CW)) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (hold_clr),
        .en_i      (hold_en),
        .limit_i   (hold_lim),
        .reached_o (hold_reached)
    );

    // Gap timer: runs everywhere except during a frame transfer.
    assign gap_en = (state_q != ST_FRAME_WAIT);

    oled_sched_timer #(.W(CW)) u_gap (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (gap_clr),
        .en_i      (gap_en),
        .limit_i   (GAP_LIM),
        .reached_o (gap_reached)
    );

    // Idle timer: restarted on every entry to IDLE so a stale count left by
    // a watchdog abort cannot fire an early forced refresh.
    assign idle_clr = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    assign idle_en  = (state_q == ST_IDLE);

    oled_sched_timer #(.W(CW)) u_idle (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (idle_clr),
        .en_i      (idle_en),
        .limit_i   (IDLE_LIM),
        .reached_o (idle_reached)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        kind_d    = kind_q;
        sp_d      = screen_param_q;
        nv_d      = needs_values_q;
        err_d     = err_q;
        fc_d      = fc_q;
        gap_clr   = 1'b0;
        gap_sat_d = gap_sat_q;
        unique case (state_q)
            ST_POWERUP: begin
                if (hold_reached) state_d = ST_INIT_START;
            end
            ST_INIT_START: begin
                state_d = ST_INIT_WAIT;
                start_d = 1'b1;
                kind_d  = KIND_INIT;
            end
            ST_INIT_WAIT: begin
                if (done_v) begin
                    // First frame after init is not rate limited.
                    state_d   = ST_IDLE;
                    gap_clr   = 1'b1;
                    gap_sat_d = 1'b1;
                end else if (hold_reached) begin
                    state_d = ST_POWERUP;
                    err_d   = 1'b1;
                end
            end
            ST_IDLE: begin
                // Dirty and forced conditions together still yield one frame.
                if ((dirty && gap_ok) || idle_reached) state_d = ST_FRAME_START;
            end
            ST_FRAME_START: begin
                state_d = ST_FRAME_WAIT;
                start_d = 1'b1;
                kind_d  = KIND_FRAME;
                sp_d    = screen_param;
                nv_d    = needs_values;
            end
            ST_FRAME_WAIT: begin
                if (done_v) begin
                    state_d   = ST_IDLE;
                    fc_d      = fc_q + 16'd1;
                    gap_clr   = 1'b1;
                    gap_sat_d = 1'b0;
                end else if (hold_reached) begin
                    state_d = ST_POWERUP;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_POWERUP;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_POWERUP;
            start_q        <= 1'b0;
            kind_q         <= KIND_INIT;
            screen_param_q <= '0;
            needs_values_q <= '0;
            ready_q        <= 1'b0;
            err_q          <= 1'b0;
            fc_q           <= '0;
            gap_sat_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            kind_q         <= kind_d;
            screen_param_q <= sp_d;
            needs_values_q <= nv_d;
            ready_q        <= ready_d;
            err_q          <= err_d;
            fc_q           <= fc_d;
            gap_sat_q      <= gap_sat_d;
        end
    end

    assign start       = start_q;
    assign start_kind  = kind_q;
    assign ready       = ready_q;
    assign err         = err_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_oled_refresh_scheduler.sv
// Scoreboard bench for the OLED refresh scheduler: expected start records
// are queued when stimulus is driven and checked when start pulses.
module tb_oled_refresh_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  screen_param = '0;
    logic [32:0] needs_values = '0;
    logic        seq_done = 1'b0;
    logic        start, start_kind, ready, err;
    logic [7:0]  screen_param_q;
    logic [32:0] needs_values_q;
    logic [15:0] frame_count;

    typedef struct {
        logic        kind;
        logic [7:0]  sp;
        logic [32:0] nv;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;
    int   start_seen = 0;
    int   start_cyc  = 0;

    oled_refresh_scheduler #(
        .INIT_DELAY_CYCLES (10),
        .MIN_GAP_CYCLES    (20),
        .MAX_IDLE_CYCLES   (100),
        .TIMEOUT_CYCLES    (50)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .screen_param   (screen_param),
        .needs_values   (needs_values),
        .seq_done       (seq_done),
        .start          (start),
        .start_kind     (start_kind),
        .screen_param_q (screen_param_q),
        .needs_values_q (needs_values_q),
        .ready          (ready),
        .err            (err),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every start must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && start) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("start_kind", start_kind, e.kind);
                chk("screen_q", screen_param_q, e.sp);
                chk("needs_q", needs_values_q, e.nv);
            end
            start_seen <= start_seen + 1;
            start_cyc  <= cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic k, input logic [7:0] sp, input logic [32:0] nv);
        exp_t e;
        e.kind = k; e.sp = sp; e.nv = nv;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int s0 = start_seen;
        int n  = 0;
        while (start_seen == s0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, start_seen != s0, 1'b1);
    endtask

    // seq_done is sampled on the n-th edge from now.
    task automatic done_after(input int n);
        repeat (n - 1) step();
        seq_done = 1'b1;
        step();
        seq_done = 1'b0;
    endtask

    initial begin
        int c0, d, s, e_cyc, s0, n;

        // Reset state
        repeat (3) step();
        chk("rst_start", start, 1'b0);
        chk("rst_kind", start_kind, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_fc", frame_count, 16'd0);
        chk("rst_sp_q", screen_param_q, 8'h00);
        chk("rst_nv_q", needs_values_q, 33'h0);

        // Power-up: init start 11 edges after release
        rst_n = 1'b1;
        push(1'b0, 8'h00, 33'h0);
        wait_start("init_start", 40);
        chk("init_cyc", start_cyc, 11);
        done_after(5);
        chk("init_ready", ready, 1'b1);
        chk("init_fc", frame_count, 16'd0);

        // Change detect, with needs changes coalesced during the transfer
        c0 = cyc;
        screen_param = 8'h03;
        push(1'b1, 8'h03, 33'h0);
        step();
        chk("ready_drop", ready, 1'b0);
        wait_start("chg_start", 20);
        chk("chg_lat", start_cyc - c0, 2);
        step(); needs_values = 33'h0_0000_0001;
        step(); needs_values = 33'h0_1234_5678;
        step(); needs_values = 33'h1_0000_00FF;
        chk("kind_hold", start_kind, 1'b1);
        push(1'b1, 8'h03, 33'h1_0000_00FF);
        done_after(5);
        d = cyc;
        chk("chg_fc", frame_count, 16'd1);

        // Rate limit: one frame, no earlier than the gap
        wait_start("gap_start", 60);
        chk("gap_min", (start_cyc - d) >= 20, 1'b1);
        done_after(5);
        chk("gap_fc", frame_count, 16'd2);

        // Forced refresh; first pass also bounces an input back to the snapshot
        for (int i = 0; i < 2; i++) begin
            d  = cyc;
            s0 = start_seen;
            for (int k = 1; k <= 60; k++) begin
                step();
                if (i == 0 && k == 2) screen_param = 8'h05;
                if (i == 0 && k == 5) screen_param = 8'h03;
            end
            chk("quiet", start_seen - s0, 0);
            push(1'b1, 8'h03, 33'h1_0000_00FF);
            wait_start("force_start", 80);
            chk("force_lat", start_cyc - d, 102);
            done_after(5);
            chk("force_fc", frame_count, 16'(3 + i));
        end

        // Watchdog: no seq_done in FRAME_WAIT
        screen_param = 8'h07;
        push(1'b1, 8'h07, 33'h1_0000_00FF);
        wait_start("wd_start", 30);
        s = start_cyc;
        n = 0;
        while (!err && n < 100) begin
            step();
            n++;
        end
        e_cyc = cyc;
        chk("wd_err", err, 1'b1);
        chk("wd_lat", e_cyc - s, 50);
        chk("wd_ready", ready, 1'b0);
        chk("wd_fc", frame_count, 16'd4);
        push(1'b0, 8'h07, 33'h1_0000_00FF);
        step(); seq_done = 1'b1;
        step(); seq_done = 1'b0;
        wait_start("wd_init", 30);
        chk("wd_init_lat", start_cyc - e_cyc, 11);
        done_after(5);
        chk("wd_err_sticky", err, 1'b1);
        chk("wd_ready2", ready, 1'b1);
        chk("wd_fc2", frame_count, 16'd4);

        // Reset in the middle of a frame transfer
        screen_param = 8'h09;
        push(1'b1, 8'h09, 33'h1_0000_00FF);
        wait_start("mr_start", 30);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("mr_start0", start, 1'b0);
        chk("mr_kind0", start_kind, 1'b0);
        chk("mr_sp0", screen_param_q, 8'h00);
        chk("mr_nv0", needs_values_q, 33'h0);
        chk("mr_fc0", frame_count, 16'd0);
        chk("mr_ready0", ready, 1'b0);
        chk("mr_err0", err, 1'b0);
        step();
        rst_n = 1'b1;
        push(1'b0, 8'h00, 33'h0);
        wait_start("mr_init", 40);
        chk("mr_init_cyc", start_cyc, 11);
        push(1'b1, 8'h09, 33'h1_0000_00FF);
        done_after(5);
        wait_start("mr_frame", 20);
        done_after(5);
        chk("mr_fc", frame_count, 16'd1);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
